// File: rtl/branch_target_predictor_pkg.sv
// Shared branch-predictor constants: 2-bit counter encodings and default table sizing.
package branch_target_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int unsigned DEFAULT_IDX_BITS = 5;

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// Combinational next state for a 2-bit saturating direction counter.
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       force_st,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (force_st) begin
      ctr_next = CTR_ST;
    end else if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup, registered EX update.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IDX_BITS = DEFAULT_IDX_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_is_branch
);

  localparam int unsigned TagBits = XLEN - IDX_BITS - 2;
  localparam int unsigned Entries = 1 << IDX_BITS;

  // Word-aligned key: low IDX_BITS are the index, the rest is the tag.
  function automatic logic [XLEN-3:0] pc_key(input logic [XLEN-1:0] pc);
    return pc[XLEN-1:2];
  endfunction

  logic [XLEN-3:0]     if_key, upd_key;
  logic [IDX_BITS-1:0] if_idx, upd_idx;
  logic [TagBits-1:0]  if_tag, upd_tag;

  logic                tbl_valid  [Entries];
  logic [TagBits-1:0]  tbl_tag    [Entries];
  logic [XLEN-1:0]     tbl_target [Entries];
  logic [1:0]          tbl_ctr    [Entries];

  logic       if_hit, upd_hit;
  logic [1:0] ctr_next;

  assign if_key  = pc_key(if_pc);
  assign upd_key = pc_key(upd_pc);
  assign if_idx  = if_key[IDX_BITS-1:0];
  assign if_tag  = if_key[XLEN-3:IDX_BITS];
  assign upd_idx = upd_key[IDX_BITS-1:0];
  assign upd_tag = upd_key[XLEN-3:IDX_BITS];

  assign if_hit  = tbl_valid[if_idx] && (tbl_tag[if_idx] == if_tag);
  assign upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);

  assign pred_taken  = if_hit && tbl_ctr[if_idx][1];
  assign pred_target = pred_taken ? tbl_target[if_idx] : if_pc + XLEN'(4);

  sat_counter2 u_sat_counter2 (
    .ctr      (tbl_ctr[upd_idx]),
    .taken    (upd_taken),
    .force_st (!upd_is_branch),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Entries; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= CTR_WNT;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        tbl_ctr[upd_idx] <= ctr_next;
        if (upd_taken || !upd_is_branch) tbl_target[upd_idx] <= upd_target;
      end else if (upd_taken) begin
        // Not-taken misses are never allocated so they cannot evict useful entries.
        tbl_valid[upd_idx]  <= 1'b1;
        tbl_tag[upd_idx]    <= upd_tag;
        tbl_target[upd_idx] <= upd_target;
        tbl_ctr[upd_idx]    <= upd_is_branch ? CTR_WT : CTR_ST;
      end
    end
  end

endmodule
